// File: rtl/ibex_pkg.sv
// Shared types for the multdiv arbiter: multdiv operator encoding and arbiter FSM states.
package ibex_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULL,
    MD_OP_MULH,
    MD_OP_DIV,
    MD_OP_REM
  } md_op_e;

  typedef enum logic [1:0] {
    MdArbIdle,
    MdArbBusy,
    MdArbResp
  } mdarb_state_e;

endpackage

// File: rtl/ibex_mdarb_grant.sv
// Grant selection for the multdiv arbiter. Fixed priority (lowest index) by default;
// round-robin with a pointer register when MULTDIV_ARB_ROUND_ROBIN_EN is defined.
module ibex_mdarb_grant #(
  parameter int unsigned NumReq = 2,
  localparam int unsigned IdxW = $clog2(NumReq)
) (
`ifdef MULTDIV_ARB_ROUND_ROBIN_EN
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              advance_i,
`endif
  input  logic [NumReq-1:0] valid_i,
  output logic              gnt_valid_o,
  output logic [IdxW-1:0]   gnt_idx_o,
  output logic [NumReq-1:0] gnt_oh_o
);

`ifdef MULTDIV_ARB_ROUND_ROBIN_EN
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] cand;

  // Search starts at the pointer and wraps around.
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    cand        = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = IdxW'((32'(ptr_q) + i) % NumReq);
      if (!gnt_valid_o && valid_i[cand]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = cand;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = IdxW'((32'(gnt_idx_o) + 32'd1) % NumReq);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (!gnt_valid_o && valid_i[IdxW'(i)]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = IdxW'(i);
      end
    end
  end
`endif

  assign gnt_oh_o = gnt_valid_o ? (NumReq'(1) << gnt_idx_o) : '0;

endmodule

// File: rtl/ibex_multdiv_arbiter.sv
// Shares one multdiv unit between NumReq requesters: grant, run to completion, respond.
// Grant policy is round-robin when MULTDIV_ARB_ROUND_ROBIN_EN is defined, else fixed priority.
module ibex_multdiv_arbiter
  import ibex_pkg::*;
#(
  parameter int unsigned NumReq = 2,
  localparam int unsigned IdxW = $clog2(NumReq)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumReq-1:0]             req_valid_i,
  output logic [NumReq-1:0]             req_ready_o,
  input  md_op_e [NumReq-1:0]           req_op_i,
  input  logic [NumReq-1:0][1:0]        req_signed_i,
  input  logic [NumReq-1:0][31:0]       req_a_i,
  input  logic [NumReq-1:0][31:0]       req_b_i,
  input  logic                          flush_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [IdxW-1:0]               rsp_id_o,
  output logic [31:0]                   rsp_result_o,
  output logic                          md_mult_en_o,
  output logic                          md_div_en_o,
  output md_op_e                        md_operator_o,
  output logic [1:0]                    md_signed_mode_o,
  output logic [31:0]                   md_op_a_o,
  output logic [31:0]                   md_op_b_o,
  input  logic                          md_valid_i,
  input  logic [31:0]                   md_result_i
);

  mdarb_state_e state_q, state_d;
  logic         kill_q, kill_d;
  md_op_e       op_q, op_d;
  logic [1:0]   sgn_q, sgn_d;
  logic [31:0]  a_q, a_d;
  logic [31:0]  b_q, b_d;
  logic [IdxW-1:0] id_q, id_d;
  logic [31:0]  result_q, result_d;

  logic              gnt_valid;
  logic [IdxW-1:0]   gnt_idx;
  logic [NumReq-1:0] gnt_oh;
  logic [NumReq-1:0] ready;

  ibex_mdarb_grant #(
    .NumReq (NumReq)
  ) u_grant (
`ifdef MULTDIV_ARB_ROUND_ROBIN_EN
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .advance_i   ((state_q == MdArbIdle) && gnt_valid),
`endif
    .valid_i     (req_valid_i),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx),
    .gnt_oh_o    (gnt_oh)
  );

  always_comb begin
    state_d      = state_q;
    kill_d       = kill_q;
    op_d         = op_q;
    sgn_d        = sgn_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    result_d     = result_q;
    ready        = '0;
    md_mult_en_o = 1'b0;
    md_div_en_o  = 1'b0;

    case (state_q)
      MdArbIdle: begin
        if (gnt_valid) begin
          ready   = gnt_oh;
          op_d    = req_op_i[gnt_idx];
          sgn_d   = req_signed_i[gnt_idx];
          a_d     = req_a_i[gnt_idx];
          b_d     = req_b_i[gnt_idx];
          id_d    = gnt_idx;
          kill_d  = 1'b0;
          state_d = MdArbBusy;
        end
      end
      MdArbBusy: begin
        if ((op_q == MD_OP_MULL) || (op_q == MD_OP_MULH)) begin
          md_mult_en_o = 1'b1;
        end else begin
          md_div_en_o = 1'b1;
        end
        // A flushed operation keeps stepping so the unit drains back to idle.
        if (flush_i) begin
          kill_d = 1'b1;
        end
        if (md_valid_i) begin
          kill_d = 1'b0;
          if (kill_q || flush_i) begin
            state_d = MdArbIdle;
          end else begin
            result_d = md_result_i;
            state_d  = MdArbResp;
          end
        end
      end
      MdArbResp: begin
        if (flush_i || rsp_ready_i) begin
          state_d = MdArbIdle;
        end
      end
      default: state_d = MdArbIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= MdArbIdle;
      kill_q   <= 1'b0;
      op_q     <= MD_OP_MULL;
      sgn_q    <= 2'b00;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      kill_q   <= kill_d;
      op_q     <= op_d;
      sgn_q    <= sgn_d;
      a_q      <= a_d;
      b_q      <= b_d;
      id_q     <= id_d;
      result_q <= result_d;
    end
  end

  // The grant is combinational from req_valid_i, so it must be masked while in reset.
  assign req_ready_o      = rst_i ? '0 : ready;
  assign rsp_valid_o      = (state_q == MdArbResp);
  assign rsp_id_o         = id_q;
  assign rsp_result_o     = result_q;
  assign md_operator_o    = op_q;
  assign md_signed_mode_o = sgn_q;
  assign md_op_a_o        = a_q;
  assign md_op_b_o        = b_q;

endmodule

// File: doc/ibex_multdiv_arbiter.md
IBEX_MULTDIV_ARBITER -- requirements
Module: ibex_multdiv_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 2, number of requesters sharing one multdiv unit (legal 2..4).
REQ-002 SHALL have port clk_i  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid_i  input  NumReq  request pending, one bit per requester.
REQ-005 SHALL have port req_ready_o  output  NumReq  request accepted this cycle.
REQ-006 SHALL have port req_op_i  input  NumReq x md_op_e  operation: MULL, MULH, DIV or REM.
REQ-007 SHALL have port req_signed_i  input  NumReq x 2  signed mode; bit0 = A signed, bit1 = B signed.
REQ-008 SHALL have ports req_a_i and req_b_i  input  NumReq x 32  operands A and B.
REQ-009 SHALL have port flush_i  input  1  cancel the in-flight operation and its response.
REQ-010 SHALL have ports rsp_valid_o  output  1  and rsp_ready_i  input  1  response handshake.
REQ-011 SHALL have ports rsp_id_o  output  $clog2(NumReq)  and rsp_result_o  output  32  response owner and result.
REQ-012 SHALL have ports md_mult_en_o and md_div_en_o  output  1  multdiv stepping enables.
REQ-013 SHALL have ports md_operator_o (md_op_e), md_signed_mode_o (2), md_op_a_o (32), md_op_b_o (32)  output  latched operation.
REQ-014 SHALL have ports md_valid_i  input  1  and md_result_i  input  32  multdiv completion and result.

Function
REQ-015 SHALL implement an FSM with states IDLE, BUSY, RESP.
REQ-016 In IDLE with any req_valid_i set, SHALL grant one requester and set its req_ready_o for that cycle only.
REQ-017 In the same cycle SHALL latch that requester's op, signed mode and operands and its index, then enter BUSY.
REQ-018 SHALL keep req_ready_o all zero in BUSY and RESP.
REQ-019 In BUSY SHALL assert md_mult_en_o for MULL/MULH and md_div_en_o for DIV/REM every cycle; never both; both zero outside BUSY.
REQ-020 SHALL hold the md_* operand and operator outputs stable from the cycle after grant until leaving BUSY.
REQ-021 When md_valid_i is high in BUSY, SHALL capture md_result_i in that cycle and enter RESP on the next edge.
REQ-022 In RESP SHALL assert rsp_valid_o with a stable rsp_id_o and rsp_result_o until rsp_ready_i is high, then return to IDLE.
REQ-023 Latency SHALL be: grant at cycle T, enables from T+1, rsp_valid_o one cycle after md_valid_i.
REQ-024 After a response completes, SHALL not re-grant in the same cycle; the next grant is at the earliest in the following IDLE cycle.
REQ-025 flush_i in BUSY SHALL NOT drop the enable; the unit SHALL run to md_valid_i so that it returns to its idle state; the result SHALL then be discarded and the FSM SHALL enter IDLE with no response.
REQ-026 flush_i in RESP SHALL drop rsp_valid_o on the next edge and enter IDLE; flush_i in IDLE SHALL have no effect.
REQ-027 md_valid_i outside BUSY SHALL be ignored.

Reset
REQ-028 While rst_i is high, SHALL force state IDLE, grant pointer 0, kill flag 0 and all outputs 0 (including rsp_id_o, rsp_result_o and md_*).
REQ-029 Reset asserted mid-operation SHALL abandon the operation without a response; the multdiv unit SHALL be reset together with this block.

Configuration
REQ-030 With MULTDIV_ARB_ROUND_ROBIN_EN defined, SHALL grant round-robin: search starts at the pointer; after a grant to index g, the pointer becomes (g+1) mod NumReq.
REQ-031 Without MULTDIV_ARB_ROUND_ROBIN_EN, SHALL grant fixed priority, lowest index first, and SHALL have no pointer register.

Structure
REQ-032 SHALL reuse md_op_e from ibex_pkg, and SHALL add the typedef mdarb_state_e (IDLE, BUSY, RESP) to ibex_pkg.
REQ-033 SHALL place grant selection in one sub-module, ibex_mdarb_grant, which is combinational apart from the optional pointer.

Verification
REQ-034 Single MULL from requester 0, A=7, B=6 -> rsp_id_o=0, rsp_result_o=42; md_mult_en_o high only in BUSY.
REQ-035 Signed DIV, A=-20, B=3, signed mode 2'b11 -> rsp_result_o=0xFFFFFFFA (-6); REM of the same operands -> 0xFFFFFFFE (-2).
REQ-036 DIV with B=0, A=5 -> 0xFFFFFFFF; REM with B=0, A=5 -> 5.
REQ-037 Both requesters held valid for 4 operations with round-robin enabled -> grants 0,1,0,1; with it disabled -> 0,0,0,0.
REQ-038 flush_i pulsed 3 cycles into a DIV, then a MULH 0x80000000 x 2 (signed mode 2'b11) -> no response for the DIV; the MULH returns 0xFFFFFFFF.
REQ-039 rsp_ready_i held low for 10 cycles -> rsp_valid_o, rsp_id_o and rsp_result_o stay stable and req_ready_o stays 0 throughout.
